// File: rtl/mod12_counter_if.sv
// Write-side load/direction controls and read-side count for the mod-12 counter.
// Agents drive load/mode/data_in; the counter drives data_out back.
interface count_if;
  logic       load;
  logic       mode;
  logic [3:0] data_in;
  logic [3:0] data_out;

  modport master (
    output load,
    output mode,
    output data_in,
    input  data_out
  );

  modport slave (
    input  load,
    input  mode,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/mod12_counter.sv
// Loadable 4-bit modulo-12 up/down counter, 1-cycle load/count latency, async active-high reset.
// No backpressure: it counts every cycle that is neither reset nor load; out-of-range loads clear to 0.
module mod12_counter (
  input  logic    clk,
  input  logic    reset,
  count_if.slave  cif
);

  localparam logic [3:0] CNT_MAX = 4'd11;

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Load wins over counting; the wrap points are explicit compares so the state never leaves 0..11.
  always_comb begin
    count_d = count_q;
    if (cif.load) begin
      count_d = (cif.data_in > CNT_MAX) ? 4'd0 : cif.data_in;
    end else if (cif.mode) begin
      count_d = (count_q == CNT_MAX) ? 4'd0 : count_q + 4'd1;
    end else begin
      count_d = (count_q == 4'd0) ? CNT_MAX : count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign cif.data_out = count_q;

endmodule

// File: tb/tb_mod12_counter.sv
// Directed vector table plus hand sequences and a random model check for mod12_counter.
module tb_mod12_counter;

  logic clk;
  logic reset;
  count_if cif ();

  mod12_counter dut (
    .clk   (clk),
    .reset (reset),
    .cif   (cif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       load;
    logic       mode;
    logic [3:0] din;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic rst, input logic ld, input logic md,
                              input logic [3:0] din, input logic [3:0] exp);
    vec_t v;
    v.rst  = rst;
    v.load = ld;
    v.mode = md;
    v.din  = din;
    v.exp  = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: data_out=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic md, input logic [3:0] din);
    reset       = rst;
    cif.load    = ld;
    cif.mode    = md;
    cif.data_in = din;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] model;
    logic       r_rst, r_ld, r_md;
    logic [3:0] r_din;

    // Vector table: each entry is applied for one edge, then data_out is compared.
    add(1, 0, 1, 0, 0);
    for (int i = 1; i <= 14; i++) add(0, 0, 1, 0, 4'((i) % 12));      // 1..11,0,1,2
    add(1, 1, 1, 5, 0);
    for (int i = 1; i <= 13; i++) add(0, 0, 0, 0, 4'((12 - i) % 12 == 0 && i == 12 ? 0 : (12 - (i % 12)) % 12));
    add(0, 1, 0, 9, 9);
    add(0, 0, 1, 0, 10);
    add(0, 0, 1, 0, 11);
    add(0, 0, 1, 0, 0);
    add(0, 1, 1, 3, 3);      // mode ignored on load
    add(0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 11);
    add(0, 1, 0, 13, 0);
    add(0, 0, 1, 0, 1);
    add(0, 1, 0, 12, 0);
    add(0, 0, 1, 0, 1);
    add(0, 1, 1, 14, 0);
    add(0, 0, 1, 0, 1);
    add(0, 1, 0, 15, 0);
    add(0, 0, 1, 0, 1);
    add(0, 1, 0, 11, 11);
    add(0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 11);
    add(0, 1, 0, 5, 5);
    add(0, 0, 1, 0, 6);
    add(0, 0, 0, 0, 5);      // direction change, no dead cycle
    add(0, 1, 0, 7, 7);
    add(0, 1, 1, 2, 2);
    add(0, 1, 0, 11, 11);

    drive(1, 0, 1, 0);
    #2;
    check("reset_initial", cif.data_out, 4'd0);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].mode, vecs[i].din);
      step();
      check($sformatf("vec%0d", i), cif.data_out, vecs[i].exp);
    end

    // Async reset between edges with the count at 7, held against a pending load of 5.
    drive(0, 1, 0, 7);
    step();
    check("pre_async_load7", cif.data_out, 4'd7);
    drive(0, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_immediate", cif.data_out, 4'd0);
    cif.load    = 1'b1;
    cif.data_in = 4'd5;
    step();
    check("reset_hold_edge1", cif.data_out, 4'd0);
    step();
    check("reset_hold_edge2", cif.data_out, 4'd0);
    reset = 1'b0;
    step();
    check("load_after_reset_release", cif.data_out, 4'd5);

    // Reset mid-count discards the in-flight step.
    drive(0, 0, 1, 0);
    step();
    check("count_before_midreset", cif.data_out, 4'd6);
    #3;
    reset = 1'b1;
    #1;
    check("midcount_reset", cif.data_out, 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check("count_from_zero_after_reset", cif.data_out, 4'd1);

    // Randomized run against a priority model.
    model = cif.data_out;
    for (int c = 0; c < 1000; c++) begin
      r_rst = ($urandom_range(0, 15) == 0);
      r_ld  = ($urandom_range(0, 3) == 0);
      r_md  = 1'($urandom_range(0, 1));
      r_din = 4'($urandom_range(0, 15));
      drive(r_rst, r_ld, r_md, r_din);
      if (r_rst)       model = 4'd0;
      else if (r_ld)   model = (r_din > 4'd11) ? 4'd0 : r_din;
      else if (r_md)   model = (model == 4'd11) ? 4'd0 : model + 4'd1;
      else             model = (model == 4'd0) ? 4'd11 : model - 4'd1;
      step();
      check($sformatf("rand%0d", c), cif.data_out, model);
      checks++;
      if (cif.data_out > 4'd11) begin
        errors++;
        $display("FAIL rand_range%0d: data_out=%0d expected<=11", c, cif.data_out);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
